// File: rtl/fx2_fifo_emu.sv
// FX2 slave-FIFO emulator: EP6OUT (host->FPGA) and EP8IN (FPGA->host) with
// empty/full flags, PKTEND commit and zero-length packet counting.
module fx2_fifo_emu #(
  parameter int unsigned OUT_DEPTH_LOG2 = 9,
  parameter int unsigned IN_DEPTH_LOG2  = 10,
  parameter int unsigned PKT_SIZE       = 512
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       fx2FifoSel_in,
  input  logic [7:0] fx2DataIn_in,
  output logic [7:0] fx2DataOut_out,
  output logic       fx2DataDrive_out,
  input  logic       fx2Read_in,
  input  logic       fx2OE_in,
  output logic       fx2GotData_out,
  input  logic       fx2Write_in,
  output logic       fx2GotRoom_out,
  input  logic       fx2PktEnd_in,
  input  logic [7:0] hostOutData_in,
  input  logic       hostOutValid_in,
  output logic       hostOutReady_out,
  output logic [7:0] hostInData_out,
  output logic       hostInLast_out,
  output logic       hostInValid_out,
  input  logic       hostInReady_in,
  output logic [7:0] zlpCount_out,
  output logic [1:0] error_out
);

  localparam int unsigned OW = OUT_DEPTH_LOG2;
  localparam int unsigned IW = IN_DEPTH_LOG2;
  localparam logic [OW:0] OutFull = {1'b1, {OW{1'b0}}};
  localparam logic [IW:0] InFull  = {1'b1, {IW{1'b0}}};
  localparam logic [IW:0] PktSize = (IW + 1)'(PKT_SIZE);

  logic [7:0]    out_mem [2**OW];
  logic [OW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OW:0]   out_cnt_q, out_cnt_d;
  logic          got_data_q, got_data_d;

  logic [7:0]    in_mem [2**IW];
  logic          in_last_mem [2**IW];
  logic [IW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d, in_prev;
  logic [IW:0]   in_cnt_q, in_cnt_d, in_unc_q, in_unc_d, in_unc_after, in_committed;
  logic          got_room_q, got_room_d;
  logic [7:0]    zlp_q, zlp_d;
  logic [1:0]    err_q, err_d;

  logic out_push, out_pop, out_rd_strobe;
  logic in_wr, in_wr_strobe, in_pop, in_pktend, in_auto, in_commit, in_mark_prev;

  always_comb begin
    out_rd_strobe = !fx2Read_in && !fx2FifoSel_in;
    out_push      = hostOutValid_in && (out_cnt_q != OutFull);
    out_pop       = out_rd_strobe && (out_cnt_q != '0);
    out_wr_d      = out_wr_q + OW'(out_push);
    out_rd_d      = out_rd_q + OW'(out_pop);
    out_cnt_d     = out_cnt_q + (OW + 1)'(out_push) - (OW + 1)'(out_pop);
    got_data_d    = (out_cnt_d != '0);

    in_wr_strobe  = !fx2Write_in && fx2FifoSel_in;
    in_wr         = in_wr_strobe && (in_cnt_q != InFull);
    in_committed  = in_cnt_q - in_unc_q;
    in_pop        = hostInReady_in && (in_committed != '0);
    in_pktend     = !fx2PktEnd_in && fx2FifoSel_in;
    in_unc_after  = in_unc_q + (IW + 1)'(in_wr);
    in_auto       = in_wr && (in_unc_after == PktSize);
    // PKTEND coinciding with an auto-commit folds into that single commit.
    in_commit     = in_auto || (in_pktend && (in_unc_after != '0));
    in_mark_prev  = in_pktend && !in_wr && (in_unc_q != '0);
    in_prev       = in_wr_q - IW'(1);
    in_unc_d      = in_commit ? '0 : in_unc_after;
    in_wr_d       = in_wr_q + IW'(in_wr);
    in_rd_d       = in_rd_q + IW'(in_pop);
    in_cnt_d      = in_cnt_q + (IW + 1)'(in_wr) - (IW + 1)'(in_pop);
    got_room_d    = (in_cnt_d != InFull);

    zlp_d = zlp_q + 8'(in_pktend && (in_unc_after == '0));
    err_d = err_q | {in_wr_strobe && (in_cnt_q == InFull),
                     out_rd_strobe && (out_cnt_q == '0)};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      got_data_q <= 1'b0;
      in_wr_q    <= '0;
      in_rd_q    <= '0;
      in_cnt_q   <= '0;
      in_unc_q   <= '0;
      got_room_q <= 1'b1;
      zlp_q      <= '0;
      err_q      <= '0;
    end else begin
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      got_data_q <= got_data_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      in_unc_q   <= in_unc_d;
      got_room_q <= got_room_d;
      zlp_q      <= zlp_d;
      err_q      <= err_d;
    end
  end

  // Buffer storage is not reset; pointers and counts gate visibility.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      if (out_push) out_mem[out_wr_q] <= hostOutData_in;
      if (in_wr) begin
        in_mem[in_wr_q]      <= fx2DataIn_in;
        in_last_mem[in_wr_q] <= in_commit;
      end
      if (in_mark_prev) in_last_mem[in_prev] <= 1'b1;
    end
  end

  always_comb begin
    fx2DataOut_out   = got_data_q ? out_mem[out_rd_q] : 8'h00;
    fx2DataDrive_out = !fx2OE_in && !fx2FifoSel_in;
    fx2GotData_out   = got_data_q;
    fx2GotRoom_out   = got_room_q;
    hostOutReady_out = (out_cnt_q != OutFull);
    hostInValid_out  = (in_committed != '0);
    hostInData_out   = hostInValid_out ? in_mem[in_rd_q] : 8'h00;
    hostInLast_out   = hostInValid_out && in_last_mem[in_rd_q];
    zlpCount_out     = zlp_q;
    error_out        = err_q;
  end

endmodule

// File: tb/tb_fx2_fifo_emu.sv
// Scoreboard bench for fx2_fifo_emu: a queue-based reference model predicts each
// byte and flag; monitors compare bytes as the DUT hands them out.
module tb_fx2_fifo_emu;

  localparam int OutDepth = 512;
  localparam int InDepth  = 1024;
  localparam int Pkt      = 512;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       fx2FifoSel_in = 1'b0;
  logic [7:0] fx2DataIn_in = 8'h00;
  logic [7:0] fx2DataOut_out;
  logic       fx2DataDrive_out;
  logic       fx2Read_in = 1'b1;
  logic       fx2OE_in = 1'b0;
  logic       fx2GotData_out;
  logic       fx2Write_in = 1'b1;
  logic       fx2GotRoom_out;
  logic       fx2PktEnd_in = 1'b1;
  logic [7:0] hostOutData_in = 8'h00;
  logic       hostOutValid_in = 1'b0;
  logic       hostOutReady_out;
  logic [7:0] hostInData_out;
  logic       hostInLast_out;
  logic       hostInValid_out;
  logic       hostInReady_in = 1'b0;
  logic [7:0] zlpCount_out;
  logic [1:0] error_out;

  fx2_fifo_emu #(
    .OUT_DEPTH_LOG2(9),
    .IN_DEPTH_LOG2 (10),
    .PKT_SIZE      (512)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset_in),
    .fx2FifoSel_in   (fx2FifoSel_in),
    .fx2DataIn_in    (fx2DataIn_in),
    .fx2DataOut_out  (fx2DataOut_out),
    .fx2DataDrive_out(fx2DataDrive_out),
    .fx2Read_in      (fx2Read_in),
    .fx2OE_in        (fx2OE_in),
    .fx2GotData_out  (fx2GotData_out),
    .fx2Write_in     (fx2Write_in),
    .fx2GotRoom_out  (fx2GotRoom_out),
    .fx2PktEnd_in    (fx2PktEnd_in),
    .hostOutData_in  (hostOutData_in),
    .hostOutValid_in (hostOutValid_in),
    .hostOutReady_out(hostOutReady_out),
    .hostInData_out  (hostInData_out),
    .hostInLast_out  (hostInLast_out),
    .hostInValid_out (hostInValid_out),
    .hostInReady_in  (hostInReady_in),
    .zlpCount_out    (zlpCount_out),
    .error_out       (error_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (state after the most recent edge).
  logic [7:0] exp_out[$];
  logic [8:0] exp_in[$];
  logic [7:0] pending[$];
  int         m_out_cnt = 0;
  int         m_in_total = 0;
  int         m_comm = 0;
  int         m_zlp = 0;
  logic [1:0] m_err = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic commit_pending();
    for (int i = 0; i < pending.size(); i++)
      exp_in.push_back({(i == pending.size() - 1) ? 1'b1 : 1'b0, pending[i]});
    m_comm += pending.size();
    pending.delete();
  endtask

  task automatic check_flags();
    check("gotData", fx2GotData_out, m_out_cnt > 0);
    check("outReady", hostOutReady_out, m_out_cnt < OutDepth);
    check("gotRoom", fx2GotRoom_out, m_in_total < InDepth);
    check("inValid", hostInValid_out, m_comm > 0);
    check("zlpCount", zlpCount_out, m_zlp[7:0]);
    check("error", error_out, m_err);
    if (m_out_cnt == 0) check("dataOutEmpty", fx2DataOut_out, 8'h00);
    if (m_comm == 0) check("inLastIdle", hostInLast_out, 1'b0);
  endtask

  // One clock: drive strobes (active-high here), advance model, then check flags.
  task automatic step(input logic rst, input logic hv, input logic [7:0] hd,
                      input logic rd, input logic wr, input logic [7:0] wd,
                      input logic pe, input logic sel, input logic ir);
    int  pre_out, pre_tot, pre_comm;
    bit  auto_c;
    reset_in        = rst;
    hostOutValid_in = hv;
    hostOutData_in  = hd;
    fx2Read_in      = ~rd;
    fx2Write_in     = ~wr;
    fx2DataIn_in    = wd;
    fx2PktEnd_in    = ~pe;
    fx2FifoSel_in   = sel;
    hostInReady_in  = ir;
    if (rst) begin
      exp_out.delete();
      exp_in.delete();
      pending.delete();
      m_out_cnt = 0;
      m_in_total = 0;
      m_comm = 0;
      m_zlp = 0;
      m_err = 2'b00;
    end else begin
      pre_out = m_out_cnt;
      if (!sel && rd) begin
        if (pre_out > 0) m_out_cnt--;
        else m_err[0] = 1'b1;
      end
      if (hv && pre_out < OutDepth) begin
        exp_out.push_back(hd);
        m_out_cnt++;
      end
      pre_tot  = m_in_total;
      pre_comm = m_comm;
      auto_c   = 1'b0;
      if (sel && wr) begin
        if (pre_tot < InDepth) begin
          pending.push_back(wd);
          m_in_total++;
          if (pending.size() == Pkt) begin
            commit_pending();
            auto_c = 1'b1;
          end
        end else begin
          m_err[1] = 1'b1;
        end
      end
      if (sel && pe && !auto_c) begin
        if (pending.size() > 0) commit_pending();
        else m_zlp = (m_zlp + 1) % 256;
      end
      if (ir && pre_comm > 0) begin
        m_comm--;
        m_in_total--;
      end
    end
    @(posedge clk);
    #1;
    check_flags();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // EP6OUT monitor: the head byte must match whenever the FPGA pops.
  initial forever begin
    @(negedge clk);
    if (!reset_in && !fx2Read_in && !fx2FifoSel_in && fx2GotData_out) begin
      if (exp_out.size() == 0) check("ep6_unexpected", 1'b1, 1'b0);
      else check("ep6_data", fx2DataOut_out, exp_out.pop_front());
    end
  end

  // EP8IN monitor: each host pop must match the next committed {last,data}.
  initial forever begin
    @(negedge clk);
    if (!reset_in && hostInValid_out && hostInReady_in) begin
      if (exp_in.size() == 0) check("ep8_unexpected", 1'b1, 1'b0);
      else check("ep8_byte", {hostInLast_out, hostInData_out}, exp_in.pop_front());
    end
  end

  initial begin
    int budget;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();

    // Loopback 0x00..0x0F through EP6OUT.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("dataDrive_sel0", fx2DataDrive_out, 1'b1);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    fx2OE_in = 1'b1;
    #1 check("dataDrive_oeHigh", fx2DataDrive_out, 1'b0);
    fx2OE_in = 1'b0;
    fx2FifoSel_in = 1'b1;
    #1 check("dataDrive_sel1", fx2DataDrive_out, 1'b0);

    // Fill EP6OUT, offer a 513th byte, then one read frees a slot.
    for (int i = 0; i < OutDepth; i++)
      step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < OutDepth - 1; i++)
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overfill EP8IN with host stalled, then drain two auto-committed packets.
    for (int i = 0; i < 1030; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    budget = 0;
    while (m_comm > 0 && budget < 2000) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      budget++;
    end
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Three bytes then PKTEND, then a lone PKTEND for a ZLP.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // Write with PKTEND on the same edge, then a read from empty EP6OUT.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Buffer traffic both ways plus 7 uncommitted bytes, then reset.
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), i == 99, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("rst_dataOut", fx2DataOut_out, 8'h00);
    check("rst_inLast", hostInLast_out, 1'b0);

    // Randomised soak with backpressure on all sides.
    for (int i = 0; i < 4000; i++) begin
      step(1'b0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 3) != 0, 8'($urandom), ($urandom % 20) == 0,
           1'($urandom), ($urandom % 3) == 0);
    end
    budget = 0;
    while ((m_comm > 0 || m_out_cnt > 0) && budget < 3000) begin
      step(1'b0, 1'b0, 8'h00, m_out_cnt > 0, 1'b0, 8'h00, 1'b0, m_out_cnt == 0, 1'b1);
      budget++;
    end
    check("drain_done", (m_comm > 0 || m_out_cnt > 0), 1'b0);
    check("ep6_queue_empty", exp_out.size(), 0);
    check("ep8_queue_empty", exp_in.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx2_fifo_emu.md
Name: fx2_fifo_emu

Overview:
- Synthesizable emulator of the FX2 side of the slave-FIFO link that comm_fpga drives. It models EP6OUT (host→FPGA) and EP8IN (FPGA→host), including empty/full flags, PKTEND commit and zero-length packets.
- A host-side byte-stream pair replaces USB, so comm_fpga-based designs can be looped back and soak-tested on-chip or in simulation without an FX2.
- Sits between a stimulus/checker engine and comm_fpga's fx2* pins. Tristate resolution is done at top level.

Parameters:
- OUT_DEPTH_LOG2, 9, log2 of EP6OUT buffer depth in bytes.
- IN_DEPTH_LOG2, 10, log2 of EP8IN buffer depth in bytes.
- PKT_SIZE, 512, EP8IN auto-commit packet length in bytes. Must be ≤ 2**IN_DEPTH_LOG2.

Ports:
- clk_in  in  1  single clock (48MHz FX2 interface clock).
- reset_in  in  1  synchronous, active-high reset.
- fx2FifoSel_in  in  1  0 = EP6OUT addressed, 1 = EP8IN addressed.
- fx2DataIn_in  in  8  byte driven by the FPGA during writes.
- fx2DataOut_out  out  8  EP6OUT head byte.
- fx2DataDrive_out  out  1  1 = emulator drives the data bus.
- fx2Read_in  in  1  active-low SLRD.
- fx2OE_in  in  1  active-low SLOE.
- fx2GotData_out  out  1  active-high: EP6OUT non-empty.
- fx2Write_in  in  1  active-low SLWR.
- fx2GotRoom_out  out  1  active-high: EP8IN not full.
- fx2PktEnd_in  in  1  active-low PKTEND.
- hostOutData_in  in  8  host→EP6OUT byte.
- hostOutValid_in  in  1  host byte valid.
- hostOutReady_out  out  1  EP6OUT can accept a byte.
- hostInData_out  out  8  EP8IN→host byte.
- hostInLast_out  out  1  byte is the last of its packet.
- hostInValid_out  out  1  committed byte available.
- hostInReady_in  in  1  host accepts byte.
- zlpCount_out  out  8  count of zero-length packets committed (wraps at 255→0).
- error_out  out  2  sticky {bit1 overflow: write when full, bit0 underflow: read when empty}.

Behaviour:
- Reset (sync, priority over all): both buffers flushed; all pointers/counts = 0; fx2GotData_out=0, fx2GotRoom_out=1, hostOutReady_out=1, hostInValid_out=0, hostInLast_out=0, zlpCount_out=0, error_out=0, fx2DataOut_out=0. Mid-packet data is discarded, not committed.
- EP6OUT, host push:
  - Accepted on an edge when hostOutValid_in && hostOutReady_out.
  - hostOutReady_out = outCount < 2**OUT_DEPTH_LOG2, from registered state.
- EP6OUT, FPGA pop:
  - Pops on an edge when fx2Read_in=0 && fx2FifoSel_in=0 && outCount>0.
  - The pop is independent of fx2OE_in.
  - A read when empty sets error_out[0]; no state change.
- EP6OUT, data bus:
  - fx2DataOut_out = head byte, first-word-fall-through; 0 when empty.
  - fx2DataDrive_out = ~fx2OE_in & ~fx2FifoSel_in (combinational).
- EP6OUT, flag and simultaneity:
  - Simultaneous push+pop: count unchanged. When full, push is blocked even if a pop occurs the same cycle.
  - fx2GotData_out is registered and equals (outCount_next > 0), so it reflects the state after each edge with no extra lag.
- EP8IN, FPGA write:
  - Accepted on an edge when fx2Write_in=0 && fx2FifoSel_in=1 && inCount < 2**IN_DEPTH_LOG2.
  - An accepted byte is appended to the open packet and increments uncommitted.
  - A write when full sets error_out[1]; byte dropped.
- EP8IN, commit rules:
  - Auto-commit when uncommitted reaches PKT_SIZE, including the byte written this edge. That byte's last bit is set.
  - PKTEND commit: on an edge with fx2PktEnd_in=0 && fx2FifoSel_in=1.
    - If uncommitted>0, or a write occurs the same edge: commit. The last bit goes on the newest byte (the same-edge write if present, else the byte at wrPtr-1).
    - If nothing is pending: zlpCount_out += 1; no bytes emitted.
  - PKTEND on the same edge as an auto-commit: one commit only; no ZLP.
- EP8IN, host drain:
  - hostInValid_out = committed > 0.
  - Pop when valid && hostInReady_in; hostInLast_out comes from the per-byte last bit.
  - Uncommitted bytes are never visible to the host.
- EP8IN, flag:
  - fx2GotRoom_out is registered = inCount_next < 2**IN_DEPTH_LOG2. inCount includes uncommitted bytes.
  - Simultaneous FPGA write + host pop: inCount unchanged.
- Pointers wrap modulo depth; counts are one bit wider than pointers.
- Both stickies clear only on reset.

Test Plan:
- Loopback: host pushes 0x00..0x0F. FPGA reads 16 with OE low, sel=0 → fx2DataOut_out sequence 0x00..0x0F; fx2DataDrive_out=1; fx2GotData_out falls the edge after the 16th read.
- Fill EP6OUT with 512 bytes → hostOutReady_out=0. A 513th valid byte is not accepted. One FPGA read → ready=1 the same cycle after the edge.
- FPGA writes 1030 bytes with host stalled → fx2GotRoom_out=0 after byte 1024, error_out=2'b10. Release host → two 512-byte packets, last asserted on bytes 512 and 1024. Bytes 1025-1030 are dropped; no further bytes are visible.
- FPGA writes 3 bytes (0xA1,0xA2,0xA3), then PKTEND alone → host gets 3 bytes, last on 0xA3. A second lone PKTEND → zlpCount_out=1, no host data.
- Write 0xB1 with PKTEND on the same edge → single 1-byte packet, last=1, zlpCount unchanged. Read with EP6OUT empty → error_out[0]=1.
- Assert reset_in with 100 bytes buffered each way plus 7 uncommitted → next cycle all outputs at reset values. Subsequent traffic behaves as from cold reset.
